// File: rtl/usb_hub_port_ctrl.sv
// Downstream-port controller for the USB hub: per-port connect/reset/enable/suspend
// state machines plus the hub-class change bitmap feeding the interrupt endpoint.
module usb_hub_port_ctrl #(
  parameter int NUM_PORTS         = 16,
  parameter int DEBOUNCE_CYCLES   = 100,
  parameter int RESET_CYCLES      = 50,
  parameter int DISCONNECT_CYCLES = 8
) (
  input  logic                         hi_clock,
  input  logic                         reset_n,
  input  logic [2*NUM_PORTS-1:0]       port_line_state,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [$clog2(NUM_PORTS):0]   cmd_port,
  input  logic [2:0]                   cmd_op,
  input  logic [$clog2(NUM_PORTS):0]   status_port,
  output logic [7:0]                   status_word,
  output logic [NUM_PORTS-1:0]         port_connected,
  output logic [NUM_PORTS-1:0]         port_enabled,
  output logic [NUM_PORTS-1:0]         port_lowspeed,
  output logic [NUM_PORTS-1:0]         port_reset_drive,
  output logic [NUM_PORTS:0]           change_bitmap,
  output logic                         change_irq
);

  localparam int PW      = $clog2(NUM_PORTS) + 1;
  localparam int MAX_AB  = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES : RESET_CYCLES;
  localparam int MAX_CYC = (MAX_AB > DISCONNECT_CYCLES) ? MAX_AB : DISCONNECT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] DISC_LAST = CW'(DISCONNECT_CYCLES - 1);

  localparam logic [2:0] ST_DISCONNECTED = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE     = 3'd1;
  localparam logic [2:0] ST_DISABLED     = 3'd2;
  localparam logic [2:0] ST_RESETTING    = 3'd3;
  localparam logic [2:0] ST_ENABLED      = 3'd4;
  localparam logic [2:0] ST_SUSPENDED    = 3'd5;

  localparam logic [2:0] OP_SET_RESET   = 3'd1;
  localparam logic [2:0] OP_CLR_ENABLE  = 3'd2;
  localparam logic [2:0] OP_SET_SUSPEND = 3'd3;
  localparam logic [2:0] OP_CLR_SUSPEND = 3'd4;
  localparam logic [2:0] OP_CLR_C_CONN  = 3'd5;
  localparam logic [2:0] OP_CLR_C_RESET = 3'd6;
  localparam logic [2:0] OP_CLR_C_EN    = 3'd7;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  logic       cmd_fire;
  logic [7:0] port_status [NUM_PORTS];
  logic [7:0] status_sel;

  assign cmd_fire = cmd_valid & cmd_ready;

  always_ff @(posedge hi_clock or negedge reset_n) begin
    if (!reset_n) cmd_ready <= 1'b0;
    else          cmd_ready <= 1'b1;
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [2:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d, se0_cnt, se0_d;
    logic          connected, conn_d, enabled, en_d, lowspeed, ls_d, drive, drv_d;
    logic          c_conn, c_reset, c_enable;
    logic          set_cc, set_cr, set_ce;
    logic [1:0]    line;
    logic          is_se0, is_se1, live, hit;
    logic          op_set_reset, op_clr_enable, op_set_suspend, op_clr_suspend;

    assign line   = port_line_state[2*gi +: 2];
    assign is_se0 = (line == 2'b00);
    assign is_se1 = (line == 2'b11);
    assign live   = (state == ST_DISABLED) || (state == ST_ENABLED) || (state == ST_SUSPENDED);
    assign hit    = cmd_fire && (cmd_port == PW'(gi));

    assign op_set_reset   = hit && (cmd_op == OP_SET_RESET);
    assign op_clr_enable  = hit && (cmd_op == OP_CLR_ENABLE);
    assign op_set_suspend = hit && (cmd_op == OP_SET_SUSPEND);
    assign op_clr_suspend = hit && (cmd_op == OP_CLR_SUSPEND);

    // Disconnect beats SE1 error, which beats any host command for this port.
    always_comb begin
      state_d = state;
      cnt_d   = cnt;
      se0_d   = '0;
      conn_d  = connected;
      en_d    = enabled;
      ls_d    = lowspeed;
      drv_d   = drive;
      set_cc  = 1'b0;
      set_cr  = 1'b0;
      set_ce  = 1'b0;
      if (live && is_se0) se0_d = sat_inc(se0_cnt);
      if (live && is_se0 && (se0_cnt >= DISC_LAST)) begin
        state_d = ST_DISCONNECTED;
        cnt_d   = '0;
        se0_d   = '0;
        conn_d  = 1'b0;
        en_d    = 1'b0;
        ls_d    = 1'b0;
        set_cc  = 1'b1;
      end else if ((state == ST_ENABLED) && is_se1) begin
        state_d = ST_DISABLED;
        en_d    = 1'b0;
        set_ce  = 1'b1;
      end else begin
        case (state)
          ST_DISCONNECTED: begin
            if (!is_se0) begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
          ST_DEBOUNCE: begin
            if (is_se0) begin
              state_d = ST_DISCONNECTED;
              cnt_d   = '0;
            end else if (cnt >= DEB_LAST) begin
              state_d = ST_DISABLED;
              cnt_d   = '0;
              conn_d  = 1'b1;
              ls_d    = (line == 2'b01);
              set_cc  = 1'b1;
            end else begin
              cnt_d = sat_inc(cnt);
            end
          end
          ST_DISABLED: begin
            if (op_set_reset) begin
              state_d = ST_RESETTING;
              cnt_d   = '0;
              drv_d   = 1'b1;
            end
          end
          ST_RESETTING: begin
            if (cnt >= RST_LAST) begin
              state_d = ST_ENABLED;
              cnt_d   = '0;
              drv_d   = 1'b0;
              en_d    = 1'b1;
              set_cr  = 1'b1;
            end else begin
              cnt_d = sat_inc(cnt);
            end
          end
          ST_ENABLED, ST_SUSPENDED: begin
            if (op_set_reset) begin
              state_d = ST_RESETTING;
              cnt_d   = '0;
              drv_d   = 1'b1;
              en_d    = 1'b0;
            end else if (op_clr_enable) begin
              state_d = ST_DISABLED;
              en_d    = 1'b0;
            end else if ((state == ST_ENABLED) && op_set_suspend) begin
              state_d = ST_SUSPENDED;
            end else if ((state == ST_SUSPENDED) && op_clr_suspend) begin
              state_d = ST_ENABLED;
            end
          end
          default: begin
            state_d = ST_DISCONNECTED;
            cnt_d   = '0;
            conn_d  = 1'b0;
            en_d    = 1'b0;
            ls_d    = 1'b0;
            drv_d   = 1'b0;
          end
        endcase
      end
    end

    // A change bit being set on the same edge as its clear stays set.
    always_ff @(posedge hi_clock or negedge reset_n) begin
      if (!reset_n) begin
        state     <= ST_DISCONNECTED;
        cnt       <= '0;
        se0_cnt   <= '0;
        connected <= 1'b0;
        enabled   <= 1'b0;
        lowspeed  <= 1'b0;
        drive     <= 1'b0;
        c_conn    <= 1'b0;
        c_reset   <= 1'b0;
        c_enable  <= 1'b0;
      end else begin
        state     <= state_d;
        cnt       <= cnt_d;
        se0_cnt   <= se0_d;
        connected <= conn_d;
        enabled   <= en_d;
        lowspeed  <= ls_d;
        drive     <= drv_d;
        c_conn    <= (c_conn   & ~(hit && (cmd_op == OP_CLR_C_CONN)))  | set_cc;
        c_reset   <= (c_reset  & ~(hit && (cmd_op == OP_CLR_C_RESET))) | set_cr;
        c_enable  <= (c_enable & ~(hit && (cmd_op == OP_CLR_C_EN)))    | set_ce;
      end
    end

    assign port_connected[gi]   = connected;
    assign port_enabled[gi]     = enabled;
    assign port_lowspeed[gi]    = lowspeed;
    assign port_reset_drive[gi] = drive;
    assign change_bitmap[gi+1]  = c_conn | c_reset | c_enable;
    assign port_status[gi]      = {c_enable, c_reset, c_conn, lowspeed,
                                   (state == ST_SUSPENDED), (state == ST_RESETTING),
                                   enabled, connected};
  end

  assign change_bitmap[0] = 1'b0;
  assign change_irq       = |change_bitmap;

  always_comb begin
    status_sel = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (status_port == PW'(i)) status_sel = port_status[i];
    end
  end

  always_ff @(posedge hi_clock or negedge reset_n) begin
    if (!reset_n) status_word <= 8'h00;
    else          status_word <= status_sel;
  end

endmodule

// File: tb/tb_usb_hub_port_ctrl.sv
// Directed bench for usb_hub_port_ctrl with 4 ports and short debounce/reset/disconnect times.
module tb_usb_hub_port_ctrl;

  logic       hi_clock = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] port_line_state = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_port = 3'd0;
  logic [2:0] cmd_op = 3'd0;
  logic [2:0] status_port = 3'd0;
  logic [7:0] status_word;
  logic [3:0] port_connected, port_enabled, port_lowspeed, port_reset_drive;
  logic [4:0] change_bitmap;
  logic       change_irq;

  int checks = 0;
  int passed = 0;

  usb_hub_port_ctrl #(
    .NUM_PORTS(4), .DEBOUNCE_CYCLES(4), .RESET_CYCLES(6), .DISCONNECT_CYCLES(3)
  ) dut (
    .hi_clock(hi_clock), .reset_n(reset_n), .port_line_state(port_line_state),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_port(cmd_port), .cmd_op(cmd_op),
    .status_port(status_port), .status_word(status_word),
    .port_connected(port_connected), .port_enabled(port_enabled),
    .port_lowspeed(port_lowspeed), .port_reset_drive(port_reset_drive),
    .change_bitmap(change_bitmap), .change_irq(change_irq)
  );

  always #5 hi_clock = ~hi_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hi_clock);
      #1;
    end
  endtask

  task automatic set_line(input int p, input logic [1:0] v);
    port_line_state[2*p +: 2] = v;
  endtask

  task automatic send_cmd(input logic [2:0] p, input logic [2:0] op);
    cmd_port  = p;
    cmd_op    = op;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tick(2);
    checks++; if (port_connected !== 4'b0 || port_reset_drive !== 4'b0) $display("FAIL reset_ports: got conn=%b drv=%b required 0", port_connected, port_reset_drive); else passed++;
    checks++; if (cmd_ready !== 1'b0 || change_bitmap !== 5'b0 || status_word !== 8'h00) $display("FAIL reset_misc: got rdy=%b bmp=%b sw=%h required 0", cmd_ready, change_bitmap, status_word); else passed++;
    reset_n = 1'b1;
    tick(1);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", cmd_ready); else passed++;
  endtask

  task automatic test_connect;
    set_line(2, 2'b10);
    tick(3);
    checks++; if (port_connected[2] !== 1'b0) $display("FAIL connect_early: got %b required 0", port_connected[2]); else passed++;
    tick(1);
    checks++; if (port_connected[2] !== 1'b1 || port_lowspeed[2] !== 1'b0) $display("FAIL connect_p2: got conn=%b ls=%b required 1,0", port_connected[2], port_lowspeed[2]); else passed++;
    checks++; if (change_bitmap !== 5'b01000 || change_irq !== 1'b1) $display("FAIL connect_bitmap: got %b irq=%b required 01000 irq=1", change_bitmap, change_irq); else passed++;
    send_cmd(3'd2, 3'd5);
    checks++; if (change_bitmap !== 5'b00000 || change_irq !== 1'b0) $display("FAIL clr_c_conn_p2: got %b irq=%b required 00000 irq=0", change_bitmap, change_irq); else passed++;
    set_line(0, 2'b10);
    tick(3);
    set_line(0, 2'b00);
    tick(2);
    checks++; if (port_connected[0] !== 1'b0 || change_bitmap[1] !== 1'b0) $display("FAIL short_burst: got conn=%b c=%b required 0,0", port_connected[0], change_bitmap[1]); else passed++;
  endtask

  task automatic test_port_reset;
    int high_cnt;
    status_port = 3'd1;
    set_line(1, 2'b01);
    tick(4);
    checks++; if (port_connected[1] !== 1'b1 || port_lowspeed[1] !== 1'b1) $display("FAIL connect_ls_p1: got conn=%b ls=%b required 1,1", port_connected[1], port_lowspeed[1]); else passed++;
    send_cmd(3'd1, 3'd5);
    send_cmd(3'd1, 3'd1);
    high_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (port_reset_drive[1] !== 1'b1) break;
      high_cnt++;
      tick(1);
    end
    checks++; if (high_cnt !== 6) $display("FAIL reset_drive_len: got %0d cycles required 6", high_cnt); else passed++;
    checks++; if (port_enabled[1] !== 1'b1 || change_bitmap[2] !== 1'b1) $display("FAIL reset_done_p1: got en=%b c=%b required 1,1", port_enabled[1], change_bitmap[2]); else passed++;
    tick(1);
    checks++; if (status_word !== 8'b0101_0011) $display("FAIL status_p1: got %b required 01010011", status_word); else passed++;
    send_cmd(3'd1, 3'd5);
    send_cmd(3'd1, 3'd6);
    checks++; if (change_bitmap !== 5'b00000) $display("FAIL clr_changes_p1: got %b required 00000", change_bitmap); else passed++;
  endtask

  task automatic test_suspend;
    status_port = 3'd0;
    set_line(0, 2'b10);
    tick(4);
    send_cmd(3'd0, 3'd1);
    tick(6);
    checks++; if (port_enabled[0] !== 1'b1) $display("FAIL enable_p0: got %b required 1", port_enabled[0]); else passed++;
    send_cmd(3'd0, 3'd5);
    send_cmd(3'd0, 3'd6);
    send_cmd(3'd0, 3'd3);
    tick(1);
    checks++; if (status_word[3] !== 1'b1 || port_enabled[0] !== 1'b1) $display("FAIL suspend_p0: got susp=%b en=%b required 1,1", status_word[3], port_enabled[0]); else passed++;
    send_cmd(3'd0, 3'd4);
    tick(1);
    checks++; if (status_word[3] !== 1'b0) $display("FAIL resume_p0: got %b required 0", status_word[3]); else passed++;
    set_line(0, 2'b11);
    tick(1);
    set_line(0, 2'b10);
    checks++; if (port_enabled[0] !== 1'b0 || change_bitmap !== 5'b00010) $display("FAIL se1_p0: got en=%b bmp=%b required 0,00010", port_enabled[0], change_bitmap); else passed++;
    tick(1);
    checks++; if (status_word !== 8'b1000_0001) $display("FAIL status_se1_p0: got %b required 10000001", status_word); else passed++;
  endtask

  task automatic test_disconnect;
    set_line(3, 2'b10);
    tick(4);
    send_cmd(3'd3, 3'd1);
    tick(6);
    send_cmd(3'd3, 3'd5);
    send_cmd(3'd3, 3'd6);
    checks++; if (port_enabled[3] !== 1'b1 || change_bitmap[4] !== 1'b0) $display("FAIL enable_p3: got en=%b c=%b required 1,0", port_enabled[3], change_bitmap[4]); else passed++;
    set_line(3, 2'b00);
    tick(2);
    set_line(3, 2'b10);
    tick(1);
    checks++; if (port_connected[3] !== 1'b1 || port_enabled[3] !== 1'b1) $display("FAIL se0_glitch_p3: got conn=%b en=%b required 1,1", port_connected[3], port_enabled[3]); else passed++;
    set_line(3, 2'b00);
    tick(2);
    checks++; if (port_connected[3] !== 1'b1) $display("FAIL se0_two_p3: got %b required 1", port_connected[3]); else passed++;
    tick(1);
    checks++; if (port_connected[3] !== 1'b0 || port_enabled[3] !== 1'b0 || change_bitmap[4] !== 1'b1) $display("FAIL disconnect_p3: got conn=%b en=%b c=%b required 0,0,1", port_connected[3], port_enabled[3], change_bitmap[4]); else passed++;
  endtask

  task automatic test_same_edge;
    set_line(2, 2'b00);
    tick(2);
    cmd_port  = 3'd2;
    cmd_op    = 3'd5;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    checks++; if (port_connected[2] !== 1'b0 || change_bitmap[3] !== 1'b1) $display("FAIL same_edge_p2: got conn=%b c=%b required 0,1", port_connected[2], change_bitmap[3]); else passed++;
    send_cmd(3'd7, 3'd5);
    send_cmd(3'd7, 3'd2);
    send_cmd(3'd7, 3'd7);
    checks++; if (port_connected !== 4'b0011 || port_enabled !== 4'b0010) $display("FAIL bad_port_state: got conn=%b en=%b required 0011,0010", port_connected, port_enabled); else passed++;
    checks++; if (change_bitmap !== 5'b11010 || cmd_ready !== 1'b1) $display("FAIL bad_port_bitmap: got %b rdy=%b required 11010 rdy=1", change_bitmap, cmd_ready); else passed++;
  endtask

  task automatic test_async_reset;
    send_cmd(3'd1, 3'd1);
    tick(2);
    checks++; if (port_reset_drive[1] !== 1'b1) $display("FAIL drive_before_areset: got %b required 1", port_reset_drive[1]); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (port_reset_drive !== 4'b0 || port_connected !== 4'b0 || port_enabled !== 4'b0) $display("FAIL async_reset_ports: got drv=%b conn=%b en=%b required 0", port_reset_drive, port_connected, port_enabled); else passed++;
    checks++; if (change_bitmap !== 5'b0 || change_irq !== 1'b0 || cmd_ready !== 1'b0 || status_word !== 8'h00) $display("FAIL async_reset_misc: got bmp=%b irq=%b rdy=%b sw=%h required 0", change_bitmap, change_irq, cmd_ready, status_word); else passed++;
    #10;
    reset_n = 1'b1;
    tick(1);
    checks++; if (cmd_ready !== 1'b1 || port_connected !== 4'b0) $display("FAIL ready_after_areset: got rdy=%b conn=%b required 1,0000", cmd_ready, port_connected); else passed++;
  endtask

  initial begin
    test_reset();
    test_connect();
    test_port_reset();
    test_suspend();
    test_disconnect();
    test_same_edge();
    test_async_reset();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
